pc_ctrl: RTL and testbench

Program-counter control stage for the WiscSP13 unpipelined core. It sits directly downstream of the branch checker: it takes `branch_sel` along with the decoded jump, halt and exception strobes, selects the next fetch address, and holds the architectural PC, the exception PC (EPC) and the run/halt state. Its `pc` output drives instruction memory, and its `pc_plus2` output feeds the link-register write path.

---
 rtl/wisc_pkg.sv | 14 +
 rtl/dff_en.sv | 21 ++
 rtl/pc_ctrl.sv | 95 +++++++++
 tb/tb_pc_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared constants and state encoding for the WiscSP13 program-counter control stage.
package wisc_pkg;

  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC   = 16'h0000;
  localparam logic [ADDR_W-1:0] EXC_VECTOR = 16'h0002;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EXC    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/dff_en.sv
// Width-parameterised register with synchronous active-high reset and load enable.
module dff_en #(
  parameter int              W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC selection, EPC save/restore and RUN/EXC/HALTED tracking for the unpipelined core.
// Handshake: none; stall=1 means the cycle is not consumed and its strobes are dropped.
module pc_ctrl
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_sel,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic              jump_reg,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              halt,
  input  logic              siic,
  input  logic              rti,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic [ADDR_W-1:0] epc,
  output logic              halted,
  output logic              err,
  output logic [1:0]        dbg_state
);

  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, rel_target;
  logic [1:0]        state_raw_q;
  pc_state_t         state_q, state_d;
  logic              active, multi, bad, err_d, err_q;
  logic [2:0]        n_strobes;

  assign state_q    = pc_state_t'(state_raw_q);
  assign pc_plus2   = pc_q + ADDR_W'(2);
  assign rel_target = pc_plus2 + imm;
  assign active     = !stall && (state_q != HALTED);
  assign n_strobes  = 3'(halt) + 3'(siic) + 3'(rti) + 3'(jump_reg) + 3'(is_jump) + 3'(is_branch);
  assign multi      = (n_strobes > 3'd1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_plus2;
    epc_d   = epc_q;
    bad     = multi;
    if (halt) begin
      pc_d    = pc_q;
      state_d = HALTED;
    end else if (siic) begin
      if (state_q == EXC) begin
        bad = 1'b1;
      end else begin
        epc_d   = pc_plus2;
        pc_d    = EXC_VECTOR;
        state_d = EXC;
      end
    end else if (rti) begin
      if (state_q == EXC) begin
        pc_d    = epc_q;
        state_d = RUN;
      end else begin
        bad = 1'b1;
      end
    end else if (jump_reg) begin
      pc_d = reg_target;
    end else if (is_jump) begin
      pc_d = rel_target;
    end else if (is_branch && branch_sel) begin
      pc_d = rel_target;
    end
    // err is a pulse: any non-active cycle (stall or HALTED) drives it low.
    err_d = active && bad;
  end

  dff_en #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .rst(rst), .en(active), .d(pc_d), .q(pc_q)
  );

  dff_en #(.W(ADDR_W), .RST_VAL('0)) u_epc_reg (
    .clk(clk), .rst(rst), .en(active), .d(epc_d), .q(epc_q)
  );

  dff_en #(.W(2), .RST_VAL(RUN)) u_state_reg (
    .clk(clk), .rst(rst), .en(active), .d(state_d), .q(state_raw_q)
  );

  dff_en #(.W(1), .RST_VAL(1'b0)) u_err_reg (
    .clk(clk), .rst(rst), .en(1'b1), .d(err_d), .q(err_q)
  );

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign err       = err_q;
  assign halted    = (state_q == HALTED);
  assign dbg_state = state_raw_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: vector table plus stall and halt sequences, scoreboard queue.
module tb_pc_ctrl;
  import wisc_pkg::*;

  localparam int SB_W = 16 + 16 + 1 + 1 + 2;

  logic        clk = 1'b0;
  logic        rst, stall, branch_sel, is_branch, is_jump, jump_reg, halt, siic, rti;
  logic [15:0] imm, reg_target;
  logic [15:0] pc, pc_plus2, epc;
  logic        halted, err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passed = 0;
  logic [SB_W-1:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        stall;
    logic [5:0]  ctl;  // {halt, siic, rti, jump_reg, is_jump, is_branch}
    logic        bsel;
    logic [15:0] imm;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic [15:0] e_epc;
    logic        e_h;
    logic        e_err;
    logic [1:0]  e_st;
  } vec_t;

  vec_t tbl[30];

  pc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_sel(branch_sel),
    .is_branch(is_branch), .is_jump(is_jump), .jump_reg(jump_reg),
    .imm(imm), .reg_target(reg_target), .halt(halt), .siic(siic), .rti(rti),
    .pc(pc), .pc_plus2(pc_plus2), .epc(epc), .halted(halted), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(logic r, logic s, logic [5:0] c, logic b, logic [15:0] i,
                               logic [15:0] t, logic [15:0] p, logic [15:0] e, logic h,
                               logic er, logic [1:0] st);
    vec_t v;
    v.rst = r; v.stall = s; v.ctl = c; v.bsel = b; v.imm = i; v.tgt = t;
    v.e_pc = p; v.e_epc = e; v.e_h = h; v.e_err = er; v.e_st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic drive(input logic r, input logic s, input logic [5:0] c, input logic b,
                       input logic [15:0] i, input logic [15:0] t);
    rst = r; stall = s; branch_sel = b; imm = i; reg_target = t;
    {halt, siic, rti, jump_reg, is_jump, is_branch} = c;
  endtask

  // Drive one cycle, push the expectation, then pop and compare after the edge.
  task automatic apply(input vec_t v);
    logic [SB_W-1:0] e;
    drive(v.rst, v.stall, v.ctl, v.bsel, v.imm, v.tgt);
    exp_q.push_back({v.e_pc, v.e_epc, v.e_h, v.e_err, v.e_st});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pc",       pc,                e[35:20]);
    chk("epc",      epc,               e[19:4]);
    chk("halted",   16'(halted),       16'(e[3]));
    chk("err",      16'(err),          16'(e[2]));
    chk("state",    16'(dbg_state),    16'(e[1:0]));
    chk("pc_plus2", pc_plus2,          e[35:20] + 16'd2);
  endtask

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_BR   = 6'b000001;
  localparam logic [5:0] C_J    = 6'b000010;
  localparam logic [5:0] C_JR   = 6'b000100;
  localparam logic [5:0] C_RTI  = 6'b001000;
  localparam logic [5:0] C_SIIC = 6'b010000;
  localparam logic [5:0] C_HALT = 6'b100000;

  initial begin
    drive(1'b1, 1'b0, C_NONE, 1'b0, 16'h0, 16'h0);
    //              rst  stl ctl          bs   imm      tgt      pc       epc      h    e    st
    tbl[0]  = row(1, 0, C_NONE,      0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, RUN);
    tbl[1]  = row(0, 0, C_NONE,      0, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 0, 0, RUN);
    tbl[2]  = row(0, 0, C_NONE,      1, 16'h0100, 16'h0000, 16'h0004, 16'h0000, 0, 0, RUN);
    tbl[3]  = row(0, 0, C_NONE,      0, 16'h0000, 16'h0000, 16'h0006, 16'h0000, 0, 0, RUN);
    tbl[4]  = row(0, 0, C_JR,        0, 16'h0000, 16'h0010, 16'h0010, 16'h0000, 0, 0, RUN);
    tbl[5]  = row(0, 0, C_BR,        1, 16'hFFF0, 16'h0000, 16'h0002, 16'h0000, 0, 0, RUN);
    tbl[6]  = row(0, 0, C_JR,        0, 16'h0000, 16'h0010, 16'h0010, 16'h0000, 0, 0, RUN);
    tbl[7]  = row(0, 0, C_BR,        0, 16'hFFF0, 16'h0000, 16'h0012, 16'h0000, 0, 0, RUN);
    tbl[8]  = row(0, 0, C_JR,        0, 16'h0000, 16'h0020, 16'h0020, 16'h0000, 0, 0, RUN);
    tbl[9]  = row(0, 0, C_SIIC,      0, 16'h0000, 16'h0000, 16'h0002, 16'h0022, 0, 0, EXC);
    tbl[10] = row(0, 0, C_NONE,      0, 16'h0000, 16'h0000, 16'h0004, 16'h0022, 0, 0, EXC);
    tbl[11] = row(0, 0, C_NONE,      0, 16'h0000, 16'h0000, 16'h0006, 16'h0022, 0, 0, EXC);
    tbl[12] = row(0, 0, C_RTI,       0, 16'h0000, 16'h0000, 16'h0022, 16'h0022, 0, 0, RUN);
    tbl[13] = row(0, 0, C_JR,        0, 16'h0000, 16'h0030, 16'h0030, 16'h0022, 0, 0, RUN);
    tbl[14] = row(0, 0, C_JR | C_BR, 1, 16'h0040, 16'h1234, 16'h1234, 16'h0022, 0, 1, RUN);
    tbl[15] = row(0, 0, C_NONE,      0, 16'h0000, 16'h0000, 16'h1236, 16'h0022, 0, 0, RUN);
    tbl[16] = row(0, 0, C_SIIC,      0, 16'h0000, 16'h0000, 16'h0002, 16'h1238, 0, 0, EXC);
    tbl[17] = row(0, 0, C_SIIC,      0, 16'h0000, 16'h0000, 16'h0004, 16'h1238, 0, 1, EXC);
    tbl[18] = row(0, 0, C_RTI,       0, 16'h0000, 16'h0000, 16'h1238, 16'h1238, 0, 0, RUN);
    tbl[19] = row(0, 0, C_RTI,       0, 16'h0000, 16'h0000, 16'h123A, 16'h1238, 0, 1, RUN);
    tbl[20] = row(0, 0, C_JR,        0, 16'h0000, 16'hFFFE, 16'hFFFE, 16'h1238, 0, 0, RUN);
    tbl[21] = row(0, 0, C_NONE,      0, 16'h0000, 16'h0000, 16'h0000, 16'h1238, 0, 0, RUN);
    tbl[22] = row(0, 0, C_JR | C_J,  0, 16'h0008, 16'h0040, 16'h0040, 16'h1238, 0, 1, RUN);
    tbl[23] = row(0, 1, C_HALT,      0, 16'h0000, 16'h0000, 16'h0040, 16'h1238, 0, 0, RUN);
    tbl[24] = row(0, 0, C_HALT,      0, 16'h0000, 16'h0000, 16'h0040, 16'h1238, 1, 0, HALTED);
    tbl[25] = row(1, 0, C_HALT,      0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, RUN);
    tbl[26] = row(0, 0, C_J,         0, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 0, 0, RUN);
    tbl[27] = row(0, 0, C_SIIC,      0, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 0, 0, EXC);
    tbl[28] = row(1, 1, C_RTI,       0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, RUN);
    tbl[29] = row(0, 0, C_RTI,       0, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 0, 1, RUN);

    for (int i = 0; i <= 21; i++) apply(tbl[i]);

    // Stall at pc=0x0000 with a jump pending: nothing moves.
    for (int k = 0; k < 4; k++)
      apply(row(0, 1, C_J, 0, 16'(($urandom_range(1, 255)) * 2), 16'h0000,
                16'h0000, 16'h1238, 0, 0, RUN));

    for (int i = 22; i <= 24; i++) apply(tbl[i]);

    // HALTED ignores strobes and stall for ten cycles.
    for (int k = 0; k < 10; k++)
      apply(row(0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                16'h0040, 16'h1238, 1, 0, HALTED));

    for (int i = 25; i <= 29; i++) apply(tbl[i]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
